// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: BCD up/down counter with run/limit FSM, 4-deep lap buffer and 4-digit display scan
module bcd_count_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       scan_tick,
  input  logic       start_pb,
  input  logic       dir_pb,
  input  logic       rec_pb,
  input  logic       recall_pb,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic [3:0] lap_tens,
  output logic [3:0] lap_ones,
  output logic [2:0] lap_count,
  output logic [3:0] DIGIT,
  output logic [3:0] value,
  output logic       running,
  output logic       max,
  output logic       min
);
  typedef enum logic [1:0] {IDLE, RUN, LIMIT} state_t;
  state_t state_q, state_d;
  logic dir_q;
  logic [3:0] tens_q, ones_q, tens_d, ones_d;
  logic [3:0] digit_q, digit_d, value_q, value_d;
  logic [7:0] lap_mem [4];
  logic [7:0] lap_q;
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] lap_count_q;
  logic is_99, is_00, at_bound, step, rec_ok, rcl_ok;
  assign is_99 = tens_q == 4'd9 && ones_q == 4'd9;
  assign is_00 = tens_q == 4'd0 && ones_q == 4'd0;
  // dir_q=1 means counting down; a same-cycle tick always sees the old direction
  assign at_bound = dir_q ? is_00 : is_99;
  assign step = state_q == RUN && tick && !start_pb && !at_bound;
  assign rec_ok = rec_pb && lap_count_q < 3'd4;
  // recall is dropped whenever rec_pb is present, even if the record itself is refused
  assign rcl_ok = recall_pb && !rec_pb && lap_count_q != 3'd0;
  // FSM state register
  always_ff @(posedge clk)
    state_q <= reset ? IDLE : state_d;
  // FSM next state; start_pb outranks tick and dir_pb
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_pb ? RUN : IDLE;
      RUN:     state_d = start_pb ? IDLE : (tick && at_bound) ? LIMIT : RUN;
      LIMIT:   state_d = start_pb ? IDLE : dir_pb ? RUN : LIMIT;
      default: state_d = IDLE;
    endcase
  end
  // FSM status outputs
  always_comb begin
    running = state_q == RUN;
    max = !dir_q && is_99;
    min = dir_q && is_00;
  end
  // BCD step in the pre-edge direction
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (step) begin
      ones_d = dir_q ? (ones_q == 4'd0 ? 4'd9 : ones_q - 4'd1) : (ones_q == 4'd9 ? 4'd0 : ones_q + 4'd1);
      tens_d = dir_q ? (ones_q == 4'd0 ? tens_q - 4'd1 : tens_q) : (ones_q == 4'd9 ? tens_q + 4'd1 : tens_q);
    end
  end
  // count and direction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      dir_q <= 1'b0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
      dir_q <= dir_q ^ dir_pb;
    end
  end
  // lap storage is not cleared; lap_count gates every read of it
  always_ff @(posedge clk)
    if (rec_ok) lap_mem[wr_ptr_q] <= {tens_q, ones_q};
  // lap pointers, occupancy and recalled value
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      lap_count_q <= 3'd0;
      lap_q <= 8'd0;
    end else if (rec_ok) begin
      wr_ptr_q <= wr_ptr_q + 2'd1;
      lap_count_q <= lap_count_q + 3'd1;
    end else if (rcl_ok) begin
      lap_q <= lap_mem[rd_ptr_q];
      rd_ptr_q <= ({1'b0, rd_ptr_q} + 3'd1 == lap_count_q) ? 2'd0 : rd_ptr_q + 2'd1;
    end
  end
  // scan rotation; value picks the nibble for the new digit from pre-edge registers
  always_comb begin
    digit_d = digit_q;
    value_d = value_q;
    if (scan_tick) begin
      digit_d = (digit_q inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}) ? {digit_q[2:0], digit_q[3]} : 4'b1110;
      value_d = digit_d == 4'b0111 ? tens_q : digit_d == 4'b1011 ? ones_q : digit_d == 4'b1101 ? lap_q[7:4] : lap_q[3:0];
    end
  end
  // display registers
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= 4'b1110;
      value_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
      value_q <= value_d;
    end
  end
  assign cnt_tens = tens_q;
  assign cnt_ones = ones_q;
  assign lap_tens = lap_q[7:4];
  assign lap_ones = lap_q[3:0];
  assign lap_count = lap_count_q;
  assign DIGIT = digit_q;
  assign value = value_q;
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb_bcd_count_ctrl: table-driven check of count FSM and lap buffer, plus hand-written scan sequence
module tb_bcd_count_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0, tick = 1'b0, scan_tick = 1'b0, start_pb = 1'b0;
  logic dir_pb = 1'b0, rec_pb = 1'b0, recall_pb = 1'b0;
  logic [3:0] cnt_tens, cnt_ones, lap_tens, lap_ones, DIGIT, value;
  logic [2:0] lap_count;
  logic running, max, min;
  bcd_count_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .scan_tick(scan_tick), .start_pb(start_pb),
    .dir_pb(dir_pb), .rec_pb(rec_pb), .recall_pb(recall_pb),
    .cnt_tens(cnt_tens), .cnt_ones(cnt_ones), .lap_tens(lap_tens), .lap_ones(lap_ones),
    .lap_count(lap_count), .DIGIT(DIGIT), .value(value),
    .running(running), .max(max), .min(min)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r, s, d, t, rc, rl;
    int n;
    logic [7:0] cnt, lap;
    logic [2:0] lc;
    logic run, mx, mn;
  } vec_t;
  vec_t v[$];
  int checks = 0, errors = 0;
  task automatic add(input logic r, s, d, t, rc, rl, input int n, input logic [7:0] cnt, lap,
                     input logic [2:0] lc, input logic run, mx, mn);
    v.push_back('{r, s, d, t, rc, rl, n, cnt, lap, lc, run, mx, mn});
  endtask
  task automatic cycle(input logic r, s, d, t, rc, rl, sc);
    {reset, start_pb, dir_pb, tick, rec_pb, recall_pb, scan_tick} = {r, s, d, t, rc, rl, sc};
    @(posedge clk);
    #1;
    {reset, start_pb, dir_pb, tick, rec_pb, recall_pb, scan_tick} = 7'd0;
  endtask
  task automatic chk_scan(input string name, input logic [3:0] dg, vl);
    checks++;
    if (DIGIT !== dg || value !== vl) begin
      errors++;
      $display("FAIL %s got DIGIT=%b value=%0d want DIGIT=%b value=%0d", name, DIGIT, value, dg, vl);
    end
  endtask
  logic [21:0] got, exp;
  initial begin
    //  r  s  d  t  rc rl  n   cnt    lap    lc run max min
    add(1, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 12, 8'h12, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 86, 8'h98, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  1, 8'h99, 8'h00, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0,  1, 8'h99, 8'h00, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0,  1, 8'h99, 8'h00, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0,  1, 8'h99, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  1, 8'h98, 8'h00, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  5, 8'h05, 8'h00, 0, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0,  1, 8'h06, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  1, 8'h05, 8'h00, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0,  1, 8'h05, 8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  3, 8'h03, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,  1, 8'h03, 8'h00, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  4, 8'h07, 8'h00, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0,  1, 8'h08, 8'h00, 2, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  3, 8'h11, 8'h00, 2, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,  1, 8'h11, 8'h00, 3, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  4, 8'h15, 8'h00, 3, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,  1, 8'h15, 8'h00, 4, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  5, 8'h20, 8'h00, 4, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,  1, 8'h20, 8'h00, 4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 8'h20, 8'h03, 4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 8'h20, 8'h07, 4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 8'h20, 8'h11, 4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 8'h20, 8'h15, 4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 8'h20, 8'h03, 4, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0,  9, 8'h09, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1,  1, 8'h09, 8'h00, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 8'h09, 8'h09, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 8'h09, 8'h09, 1, 1, 0, 0);
    add(1, 0, 0, 1, 1, 0,  1, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  1, 8'h00, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 17, 8'h17, 8'h00, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,  1, 8'h17, 8'h00, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 8'h17, 8'h17, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 25, 8'h42, 8'h17, 1, 1, 0, 0);
    foreach (v[i]) begin
      repeat (v[i].n) cycle(v[i].r, v[i].s, v[i].d, v[i].t, v[i].rc, v[i].rl, 1'b0);
      checks++;
      got = {cnt_tens, cnt_ones, lap_tens, lap_ones, lap_count, running, max, min};
      exp = {v[i].cnt, v[i].lap, v[i].lc, v[i].run, v[i].mx, v[i].mn};
      if (got !== exp) begin
        errors++;
        $display("FAIL row%0d got cnt=%h lap=%h lc=%0d run/max/min=%b%b%b want cnt=%h lap=%h lc=%0d run/max/min=%b%b%b",
                 i, got[21:14], got[13:6], got[5:3], got[2], got[1], got[0],
                 exp[21:14], exp[13:6], exp[5:3], exp[2], exp[1], exp[0]);
      end
    end
    chk_scan("scan_idle", 4'b1110, 4'd0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk_scan("scan1", 4'b1101, 4'd1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk_scan("scan2", 4'b1011, 4'd2);
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk_scan("scan3", 4'b0111, 4'd4);
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk_scan("scan4", 4'b1110, 4'd7);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk_scan("scan_hold", 4'b1110, 4'd7);
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk_scan("scan5", 4'b1101, 4'd1);
    cycle(0, 0, 0, 1, 0, 0, 1);
    chk_scan("scan_tick_same_edge", 4'b1011, 4'd2);
    checks++;
    if ({cnt_tens, cnt_ones} !== 8'h43) begin
      errors++;
      $display("FAIL cnt_after_scan got %h want 43", {cnt_tens, cnt_ones});
    end
    cycle(1, 0, 0, 0, 0, 0, 1);
    chk_scan("scan_reset", 4'b1110, 4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
